mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port, fixed-latency unified memory between the IF-stage
// fetch port (i_*) and the MEM-stage load/store port (d_*). Each access runs
// IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> RESP, so back-to-back service
// takes MEM_LAT+3 cycles. Data accesses win over fetches. An optional guard
// forces a fetch grant after STARVE_MAX consecutive data grants made while a
// fetch was waiting.
//
// Optional feature macro: MEM_ARB_STARVE_GUARD_EN (undefined = strict data
// priority, no starvation counter).
//
// Parameters
//   AW          byte address width
//   DW          data width
//   MEM_LAT     issue-to-read-data latency of the memory, 1..7
//   STARVE_MAX  data grants tolerated while a fetch waits (guard only), 1..15
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   i_req/i_addr      fetch request (held until i_ack) and byte address
//   i_rdata/i_ack     fetched word (held until next i_ack), 1-cycle ack pulse
//   i_stall           i_req & ~i_ack, combinational
//   d_req/d_we        data request (held until d_ack), 1 = store
//   d_addr/d_wdata    data byte address and store data
//   d_rdata/d_ack     load data (held until next load ack), 1-cycle ack pulse
//   d_stall           d_req & ~d_ack, combinational
//   m_en/m_we         memory strobe (one cycle per access), write enable
//   m_addr/m_wdata    word address (byte address [AW-1:2]), write data
//   m_rdata           memory read data, valid MEM_LAT cycles after m_en
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  // fetch port
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  output logic          i_stall,
  // data port
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          d_stall,
  // memory side
  output logic          m_en,
  output logic          m_we,
  output logic [AW-3:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  if (MEM_LAT < 1 || MEM_LAT > 7 || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_param
    $error("mem_arbiter: MEM_LAT must be 1..7 and STARVE_MAX 1..15");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t     state;
  logic       owner_d;    // 1 = data port owns the current access
  logic       is_load;    // current access returns read data
  logic [2:0] lat_cnt;    // remaining WAIT cycles
  logic       fetch_favored;
  logic       grant_d;
  logic       grant_i;

  // Byte-lane bits are irrelevant to a word-addressed memory.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{i_addr[1:0], d_addr[1:0]};

`ifdef MEM_ARB_STARVE_GUARD_EN
  // Counts data grants that bypassed a waiting fetch; cleared by any fetch
  // grant. At STARVE_MAX the next contended grant goes to the fetch port.
  logic [3:0] starve_cnt;

  assign fetch_favored = (starve_cnt == 4'(STARVE_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (grant_i) begin
        starve_cnt <= '0;
      end else if (grant_d && i_req && (starve_cnt != 4'(STARVE_MAX))) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end
`else
  assign fetch_favored = 1'b0;
`endif

  // Grants are only acted on in IDLE; the FSM ignores them elsewhere.
  assign grant_d = d_req & ~(i_req & fetch_favored);
  assign grant_i = i_req & ~grant_d;

  assign i_stall = i_req & ~i_ack;
  assign d_stall = d_req & ~d_ack;

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values; blocking writes would make the FSM order-dependent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the rdata holding registers are reset too, so a reset mid-access
      // leaves no stale read data visible to the pipeline.
      state   <= IDLE;
      owner_d <= 1'b0;
      is_load <= 1'b0;
      lat_cnt <= '0;
      m_en    <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low every cycle; each state only raises
      // what it owns, so no path silently holds a stale strobe or ack.
      m_en  <= 1'b0;
      i_ack <= 1'b0;
      d_ack <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_d || grant_i) begin
            owner_d <= grant_d;
            is_load <= ~(grant_d & d_we);
            m_en    <= 1'b1;
            m_we    <= grant_d & d_we;
            m_addr  <= grant_d ? d_addr[AW-1:2] : i_addr[AW-1:2];
            if (grant_d) begin
              m_wdata <= d_wdata;
            end
            state <= ISSUE;
          end
        end

        ISSUE: begin
          m_we    <= 1'b0;
          lat_cnt <= 3'(MEM_LAT);
          state   <= WAIT;
        end

        WAIT: begin
          if (lat_cnt == 3'd1) begin
            if (is_load) begin
              if (owner_d) begin
                d_rdata <= m_rdata;
              end else begin
                i_rdata <= m_rdata;
              end
            end
            d_ack <= owner_d;
            i_ack <= ~owner_d;
            state <= RESP;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end

        // Ack is visible this cycle; requests are not sampled until IDLE.
        RESP: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Scoreboard bench for mem_arbiter (MEM_LAT=3, STARVE_MAX=2). The stimulus
// process plans each burst of requests at transaction level: it walks the
// service slots (one every MEM_LAT+3 cycles), picks a winner by the priority
// rule, applies the access to a reference memory and pushes the expected
// memory issue and acknowledge into queues. A monitor on the falling edge pops
// and compares whenever the DUT shows m_en or an ack. A fixed-latency memory
// model sits on the m_* port.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int L  = 3;
  localparam int SM = 2;

  typedef struct packed {
    int          cycle;
    logic [29:0] waddr;
    logic        we;
    logic [31:0] wdata;
  } iss_t;

  typedef struct packed {
    logic        is_d;
    int          cycle;
    logic [31:0] irdata;
    logic [31:0] drdata;
  } ack_t;

  typedef struct packed {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [7:0]  alt;    // address driven once the request has been captured
  } op_t;

  logic        clk, rst;
  logic        i_req, i_ack, i_stall;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_ack, d_stall;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        m_en, m_we;
  logic [29:0] m_addr;
  logic [31:0] m_wdata, m_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  iss_t iss_q[$];
  ack_t ack_q[$];
  op_t  bd_q[$];
  op_t  bf_q[$];

  logic [31:0] mdl_mem [64];
  logic [31:0] last_i, last_d;
`ifdef MEM_ARB_STARVE_GUARD_EN
  int starve_cnt;
`endif

  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(L), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_stall(d_stall),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- memory
  function automatic logic [31:0] init_val(input int w);
    return 32'h2000_0003 + 32'(w) * 32'h0001_0001;
  endfunction

  logic [31:0] dev_mem [64];
  logic [63:0] written = '0;
  logic [31:0] pipe [L];

  assign m_rdata = pipe[L-1];

  always @(posedge clk) begin
    if (m_en && m_we) begin
      dev_mem[m_addr[5:0]] <= m_wdata;
      written[m_addr[5:0]] <= 1'b1;
    end
    // Non-read cycles carry noise so a mistimed capture is visible.
    pipe[0] <= m_en ? (written[m_addr[5:0]] ? dev_mem[m_addr[5:0]] : init_val(int'(m_addr[5:0])))
                    : $urandom;
    for (int k = L - 1; k > 0; k--) pipe[k] <= pipe[k-1];
  end

  // ---------------------------------------------------------------- checks
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  initial begin
    iss_t ei;
    ack_t ea;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("i_stall", 64'(i_stall), 64'(i_req & ~i_ack));
        check("d_stall", 64'(d_stall), 64'(d_req & ~d_ack));
        if (m_en) begin
          if (iss_q.size() == 0) begin
            check("unexpected_issue", 64'(m_en), 64'd0);
          end else begin
            ei = iss_q.pop_front();
            check("issue_cycle", 64'(cyc), 64'(ei.cycle));
            check("m_addr", 64'(m_addr), 64'(ei.waddr));
            check("m_we", 64'(m_we), 64'(ei.we));
            if (ei.we) check("m_wdata", 64'(m_wdata), 64'(ei.wdata));
          end
        end
        if (i_ack || d_ack) begin
          if (ack_q.size() == 0) begin
            check("unexpected_ack", 64'({i_ack, d_ack}), 64'd0);
          end else begin
            ea = ack_q.pop_front();
            check("single_ack", 64'(i_ack & d_ack), 64'd0);
            check("ack_port", 64'(d_ack), 64'(ea.is_d));
            check("ack_cycle", 64'(cyc), 64'(ea.cycle));
            check("i_rdata", 64'(i_rdata), 64'(ea.irdata));
            check("d_rdata", 64'(d_rdata), 64'(ea.drdata));
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic op_t mk_op(input logic we, input logic [7:0] addr,
                                input logic [31:0] wdata, input logic [7:0] alt);
    op_t o;
    o.we = we; o.addr = addr; o.wdata = wdata; o.alt = alt;
    return o;
  endfunction

  function automatic op_t rand_op(input bit is_d);
    return mk_op(is_d ? 1'($urandom_range(0, 1)) : 1'b0, 8'($urandom),
                 $urandom, 8'($urandom));
  endfunction

  // Plans and drives the ops in bd_q/bf_q; both ports start requesting now.
  // Must be entered just after a rising edge with the DUT idle.
  task automatic run_burst();
    int   t, t0, tend, di, fi, nd, nf;
    int   ds[$], da[$], fs[$], fa[$];
    bit   dp, ip, gd;
    op_t  o;
    iss_t ei;
    ack_t ea;
    nd = bd_q.size(); nf = bf_q.size();
    t0 = cyc; t = t0; tend = t0; di = 0; fi = 0;
    // One service slot per MEM_LAT+3 cycles, winner by priority rule.
    while (di < nd || fi < nf) begin
      dp = (di < nd); ip = (fi < nf);
`ifdef MEM_ARB_STARVE_GUARD_EN
      gd = dp && !(ip && starve_cnt == SM);
      if (gd && ip && starve_cnt < SM) starve_cnt++;
      if (!gd) starve_cnt = 0;
`else
      gd = dp;
`endif
      o = gd ? bd_q[di] : bf_q[fi];
      ei.cycle = t + 1; ei.waddr = {24'd0, o.addr[7:2]}; ei.we = o.we; ei.wdata = o.wdata;
      iss_q.push_back(ei);
      if (o.we) mdl_mem[o.addr[7:2]] = o.wdata;
      else if (gd) last_d = mdl_mem[o.addr[7:2]];
      else last_i = mdl_mem[o.addr[7:2]];
      ea.is_d = gd; ea.cycle = t + L + 2; ea.irdata = last_i; ea.drdata = last_d;
      ack_q.push_back(ea);
      if (gd) begin ds.push_back(t); da.push_back(t + L + 2); di++; end
      else    begin fs.push_back(t); fa.push_back(t + L + 2); fi++; end
      tend = t + L + 2;
      t += L + 3;
    end
    // Drive: real operands until capture, noise (and maybe a dropped
    // request) afterwards, next op from the ack cycle on.
    di = 0; fi = 0;
    for (int c = t0; c <= tend; c++) begin
      while (di < nd && c >= da[di]) di++;
      while (fi < nf && c >= fa[fi]) fi++;
      if (di < nd) begin
        o = bd_q[di];
        if (c <= ds[di]) begin
          d_req = 1'b1; d_we = o.we; d_addr = {24'd0, o.addr}; d_wdata = o.wdata;
        end else begin
          d_req = ($urandom_range(0, 3) != 0); d_we = 1'($urandom);
          d_addr = {24'd0, o.alt}; d_wdata = $urandom;
        end
      end else begin
        d_req = 1'b0;
      end
      if (fi < nf) begin
        o = bf_q[fi];
        if (c <= fs[fi]) begin
          i_req = 1'b1; i_addr = {24'd0, o.addr};
        end else begin
          i_req = ($urandom_range(0, 3) != 0); i_addr = {24'd0, o.alt};
        end
      end else begin
        i_req = 1'b0;
      end
      tick();
    end
    bd_q.delete();
    bf_q.delete();
  endtask

  initial begin
    int   nd, nf, t;
    iss_t ei;
    for (int w = 0; w < 64; w++) mdl_mem[w] = init_val(w);
    last_i = '0; last_d = '0;
`ifdef MEM_ARB_STARVE_GUARD_EN
    starve_cnt = 0;
`endif
    rst = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    tick();
    check("rst_m_en", 64'(m_en), 64'd0);
    check("rst_m_we", 64'(m_we), 64'd0);
    check("rst_acks", 64'({i_ack, d_ack}), 64'd0);
    check("rst_m_addr", 64'(m_addr), 64'd0);
    check("rst_m_wdata", 64'(m_wdata), 64'd0);
    check("rst_rdata", {i_rdata, d_rdata}, 64'd0);
    tick();
    rst = 1'b0;

    // Single fetch of word 2.
    bf_q.push_back(mk_op(1'b0, 8'h08, 32'h0, 8'h3c));
    run_burst();
    // Contended: store wins, fetch follows; store address moves to 0x80
    // after capture and must not matter.
    bd_q.push_back(mk_op(1'b1, 8'h40, 32'hDEAD_BEEF, 8'h80));
    bf_q.push_back(mk_op(1'b0, 8'h08, 32'h0, 8'h44));
    run_burst();
    bd_q.push_back(mk_op(1'b0, 8'h40, 32'h0, 8'h00));
    bd_q.push_back(mk_op(1'b0, 8'h80, 32'h0, 8'h40));
    run_burst();
    bd_q.push_back(mk_op(1'b0, 8'h14, 32'h0, 8'h20));
    run_burst();
    // Both ports held: grant order depends on the starvation guard.
    for (int k = 0; k < 4; k++) bd_q.push_back(rand_op(1'b1));
    for (int k = 0; k < 2; k++) bf_q.push_back(rand_op(1'b0));
    run_burst();

    // Reset during WAIT of a load: everything clears, no ack ever follows.
    t = cyc;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h14;
    ei.cycle = t + 1; ei.waddr = 30'h5; ei.we = 1'b0; ei.wdata = '0;
    iss_q.push_back(ei);
    repeat (3) tick();
    #2 rst = 1'b1;
    d_req = 1'b0;
    #1;
    check("mid_rst_m_en", 64'(m_en), 64'd0);
    check("mid_rst_acks", 64'({i_ack, d_ack}), 64'd0);
    check("mid_rst_m_addr", 64'(m_addr), 64'd0);
    check("mid_rst_rdata", {i_rdata, d_rdata}, 64'd0);
    last_i = '0; last_d = '0;
`ifdef MEM_ARB_STARVE_GUARD_EN
    starve_cnt = 0;
`endif
    tick();
    rst = 1'b0;
    repeat (L + 4) tick();
    bd_q.push_back(mk_op(1'b0, 8'h16, 32'h0, 8'h90));
    run_burst();

    // Random bursts.
    for (int b = 0; b < 25; b++) begin
      nd = $urandom_range(0, 3);
      nf = $urandom_range(nd == 0 ? 1 : 0, 3);
      for (int k = 0; k < nd; k++) bd_q.push_back(rand_op(1'b1));
      for (int k = 0; k < nf; k++) bf_q.push_back(rand_op(1'b0));
      run_burst();
    end

    repeat (L + 4) tick();
    check("pending_issues", 64'(iss_q.size()), 64'd0);
    check("pending_acks", 64'(ack_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
